ro_deframer: RTL and testbench

//  Receive end of the shared time-multiplexed readout bus that the per-core ro_block_N tristate drivers share.

---
 rtl/ro_deframer.sv | 133 +++++++++++++
 tb/tb_ro_deframer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_deframer.sv
// Receive end of the shared time-multiplexed readout bus: mirrors the transmit
// counter, decodes the active core slot, samples the bus mid-cycle and queues records.
module ro_deframer #(
  parameter int N_BITS     = 19,
  parameter int N_CH       = 8,
  parameter int CH_W       = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              bus_eve,
  input  logic              bus_pol_eve,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_eve,
  output logic              out_pol_eve,
  output logic [N_CH-1:0]   chan_eve,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            eve;
    logic            pol;
  } rec_t;

  logic [N_BITS-1:0] b;
  logic [CH_W-1:0]   slot_ch;
  logic              slot_vld;

  rec_t              cap;
  logic              cap_vld;

  rec_t              mem [FIFO_DEPTH];
  rec_t              last;
  rec_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) b <= '0;
    else       b <= b + N_BITS'(1);
  end

  // The toggled gray bit equals the trailing-zero count of the binary value;
  // b==0 only happens on wrap from all-ones, where the top bit toggles.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    slot_ch = CH_W'(N_BITS - 1);
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (b[i]) slot_ch = CH_W'(i);
    end
    slot_vld = (int'(slot_ch) < N_CH);
  end

  // Mid-cycle sample: the transmitter drives during the high phase.
  always_ff @(negedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cap     <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap     <= '{ch: slot_ch, eve: bus_eve, pol: bus_pol_eve};
      cap_vld <= slot_vld;
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = cap_vld && (!full || pop);
  assign drop      = cap_vld && full && !pop;

  // Empty FIFO shows the last popped record so out_* hold their value.
  assign head        = out_valid ? mem[rd_ptr] : last;
  assign out_ch      = head.ch;
  assign out_eve     = head.eve;
  assign out_pol_eve = head.pol;

  // NOTE: storage array has no reset; it is only read while count says an
  // entry is valid, and out_* fall back to the reset 'last' register.
  always_ff @(posedge clk_master) begin
    if (push) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Per-channel last event is updated even when the record itself is dropped.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      chan_eve <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap_vld && (int'(cap.ch) == i)) chan_eve[i] <= cap.eve;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ro_deframer.sv
// Randomized self-checking bench for ro_deframer against a queue-based slot model.
module tb_ro_deframer;

  logic clk_master = 1'b0;
  logic rstb = 1'b0;
  logic bus_eve = 1'b0;
  logic bus_pol_eve = 1'b0;
  logic out_ready = 1'b0;

  logic       m_valid, m_eve, m_pol, m_ovf;
  logic [4:0] m_ch;
  logic [7:0] m_chan, m_drop;
  logic       s_valid, s_eve, s_pol, s_ovf;
  logic [4:0] s_ch;
  logic [3:0] s_chan;
  logic [7:0] s_drop;

  ro_deframer dut (
    .clk_master(clk_master), .rstb(rstb), .bus_eve(bus_eve), .bus_pol_eve(bus_pol_eve),
    .out_valid(m_valid), .out_ready(out_ready), .out_ch(m_ch), .out_eve(m_eve),
    .out_pol_eve(m_pol), .chan_eve(m_chan), .overflow(m_ovf), .drop_cnt(m_drop)
  );

  ro_deframer #(.N_BITS(4), .N_CH(4), .CH_W(5), .FIFO_DEPTH(4)) dut_small (
    .clk_master(clk_master), .rstb(rstb), .bus_eve(bus_eve), .bus_pol_eve(bus_pol_eve),
    .out_valid(s_valid), .out_ready(out_ready), .out_ch(s_ch), .out_eve(s_eve),
    .out_pol_eve(s_pol), .chan_eve(s_chan), .overflow(s_ovf), .drop_cnt(s_drop)
  );

  always #5 clk_master = ~clk_master;

  typedef struct {
    int ch;
    bit eve;
    bit pol;
  } mrec_t;

  int    total = 0;
  int    bad = 0;
  string tname = "";
  bit    sel = 0;
  int    nb = 19;
  int    nch = 8;

  // Model: slots counted since reset release, queue of records, sticky counters.
  int    t;
  mrec_t q[$];
  mrec_t last;
  mrec_t pend;
  bit    pend_v;
  bit [7:0] mchan;
  bit    movf;
  int    mdrops;

  function automatic int slot_of(input int tt, input int nbits);
    int v;
    int c;
    v = tt % (1 << nbits);
    if (v == 0) return nbits - 1;
    c = 0;
    while (v % 2 == 0) begin
      v = v / 2;
      c++;
    end
    return c;
  endfunction

  function automatic void mreset();
    t = 0;
    q.delete();
    last = '{0, 1'b0, 1'b0};
    pend = '{0, 1'b0, 1'b0};
    pend_v = 0;
    mchan = '0;
    movf = 0;
    mdrops = 0;
  endfunction

  function automatic bit obs_valid();
    return sel ? s_valid : m_valid;
  endfunction

  task automatic do_reset();
    rstb = 1'b0;
    bus_eve = 1'b0;
    bus_pol_eve = 1'b0;
    repeat (2) @(posedge clk_master);
    @(negedge clk_master);
    #1;
    rstb = 1'b1;
    mreset();
  endtask

  // One clock: apply the model's edge, compare outputs, then drive the new slot.
  // mode 0: bus idle, 1: random, 2: eve only at b=4,12,20, 3: both lines high.
  task automatic step(input logic rdy, input int mode);
    bit    ev;
    bit    ex_valid;
    mrec_t h;
    int    o_ch;
    bit    o_eve, o_pol, o_ovf;
    int    o_drop;
    bit [7:0] o_chan;
    int    b_now;
    @(posedge clk_master);
    #1;
    if (q.size() > 0 && out_ready) last = q.pop_front();
    if (pend_v) begin
      mchan[pend.ch] = pend.eve;
      if (q.size() < 4) q.push_back(pend);
      else begin
        movf = 1;
        if (mdrops < 255) mdrops++;
      end
    end
    t++;

    ex_valid = (q.size() > 0);
    h = ex_valid ? q[0] : last;
    o_ch   = sel ? int'(s_ch) : int'(m_ch);
    o_eve  = sel ? s_eve : m_eve;
    o_pol  = sel ? s_pol : m_pol;
    o_ovf  = sel ? s_ovf : m_ovf;
    o_drop = sel ? int'(s_drop) : int'(m_drop);
    o_chan = sel ? {4'b0, s_chan} : m_chan;
    if (!sel) mchan = mchan & 8'hFF;
    else      mchan = mchan & 8'h0F;

    total++;
    if (obs_valid() !== ex_valid) begin
      bad++;
      $display("FAIL %s t=%0d out_valid got=%0b want=%0b", tname, t, obs_valid(), ex_valid);
    end
    total++;
    if (o_ch != h.ch || o_eve != h.eve || o_pol != h.pol) begin
      bad++;
      $display("FAIL %s t=%0d head got=(ch%0d,%0b,%0b) want=(ch%0d,%0b,%0b)",
               tname, t, o_ch, o_eve, o_pol, h.ch, h.eve, h.pol);
    end
    total++;
    if (o_chan !== mchan) begin
      bad++;
      $display("FAIL %s t=%0d chan_eve got=%h want=%h", tname, t, o_chan, mchan);
    end
    total++;
    if (o_ovf !== movf || o_drop != mdrops) begin
      bad++;
      $display("FAIL %s t=%0d ovf/drops got=%0b/%0d want=%0b/%0d", tname, t, o_ovf, o_drop, movf, mdrops);
    end

    out_ready = rdy;
    b_now = t % (1 << nb);
    pend.ch = slot_of(t, nb);
    case (mode)
      1:       begin pend.eve = 1'($urandom); pend.pol = 1'($urandom); end
      2:       begin
                 ev = (b_now == 4 || b_now == 12 || b_now == 20);
                 pend.eve = ev;
                 pend.pol = 1'b0;
               end
      3:       begin pend.eve = 1'b1; pend.pol = 1'b1; end
      default: begin pend.eve = 1'b0; pend.pol = 1'b0; end
    endcase
    pend_v = (pend.ch < nch);
    bus_eve = pend.eve;
    bus_pol_eve = pend.pol;
    @(negedge clk_master);
    #1;
    bus_eve = 1'b0;
    bus_pol_eve = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    sel = 0; nb = 19; nch = 8;
    do_reset();
    total++;
    if (m_valid !== 1'b0 || m_ch !== 5'd0 || m_eve !== 1'b0 || m_pol !== 1'b0) begin
      bad++;
      $display("FAIL reset head got valid=%0b ch=%0d eve=%0b pol=%0b want all 0", m_valid, m_ch, m_eve, m_pol);
    end
    total++;
    if (m_chan !== 8'h00 || m_ovf !== 1'b0 || m_drop !== 8'd0) begin
      bad++;
      $display("FAIL reset status got chan=%h ovf=%0b drop=%0d want 0", m_chan, m_ovf, m_drop);
    end
  endtask

  task automatic test_directed_eve();
    tname = "directed_eve";
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 2);
    total++;
    if (m_chan[2] !== 1'b1) begin
      bad++;
      $display("FAIL directed_eve chan_eve[2] got=%0b want=1", m_chan[2]);
    end
  endtask

  task automatic test_sequence();
    int exp_seq[16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 4};
    tname = "sequence";
    out_ready = 1'b1;
    do_reset();
    step(1'b1, 1);
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL sequence early out_valid got=%0b want=0", m_valid);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1);
      total++;
      if (m_valid !== 1'b1 || int'(m_ch) != exp_seq[k]) begin
        bad++;
        $display("FAIL sequence rec%0d got valid=%0b ch=%0d want valid=1 ch=%0d", k, m_valid, m_ch, exp_seq[k]);
      end
    end
  endtask

  task automatic test_small_wrap();
    tname = "small_wrap";
    out_ready = 1'b1;
    do_reset();
    sel = 1; nb = 4; nch = 4;
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 3) != 0), 1);
      total++;
      if (s_valid === 1'b1 && s_ch >= 5'd4) begin
        bad++;
        $display("FAIL small_wrap forwarded slot got=%0d want<4", s_ch);
      end
    end
    sel = 0; nb = 19; nch = 8;
  endtask

  task automatic test_overflow();
    tname = "overflow";
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1);
    total++;
    if (m_ovf !== 1'b1 || m_drop !== 8'd2 || m_valid !== 1'b1 || m_ch !== 5'd0) begin
      bad++;
      $display("FAIL overflow got ovf=%0b drop=%0d valid=%0b ch=%0d want 1/2/1/0", m_ovf, m_drop, m_valid, m_ch);
    end
  endtask

  task automatic test_full_pop();
    tname = "full_pop";
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1);
    step(1'b1, 1);
    step(1'b0, 1);
    total++;
    if (m_ovf !== 1'b0 || m_drop !== 8'd0 || m_ch !== 5'd1) begin
      bad++;
      $display("FAIL full_pop got ovf=%0b drop=%0d ch=%0d want 0/0/1", m_ovf, m_drop, m_ch);
    end
    step(1'b0, 1);
    total++;
    if (m_drop !== 8'd1) begin
      bad++;
      $display("FAIL full_pop count-unchanged drop got=%0d want=1", m_drop);
    end
  endtask

  task automatic test_mid_reset();
    tname = "mid_reset";
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 3);
    rstb = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_ch !== 5'd0 || m_eve !== 1'b0 || m_pol !== 1'b0 ||
        m_chan !== 8'h00 || m_ovf !== 1'b0 || m_drop !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset got valid=%0b ch=%0d eve=%0b pol=%0b chan=%h ovf=%0b drop=%0d want all 0",
               m_valid, m_ch, m_eve, m_pol, m_chan, m_ovf, m_drop);
    end
    @(negedge clk_master);
    #1;
    rstb = 1'b1;
    mreset();
    out_ready = 1'b1;
    step(1'b1, 1);
    step(1'b1, 1);
    total++;
    if (m_valid !== 1'b1 || m_ch !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset first record got valid=%0b ch=%0d want 1/0", m_valid, m_ch);
    end
  endtask

  task automatic test_random();
    tname = "random";
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) step(($urandom_range(0, 9) < 6), 1);
  endtask

  initial begin
    test_reset();
    test_directed_eve();
    test_sequence();
    test_small_wrap();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
